// File: rtl/lap_store_pkg.sv
// ============================================================================
// watch_pkg : shared widths and FSM state encoding for the lap store
// Revision  : 1.0
// ============================================================================
`default_nettype none

package watch_pkg;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lap_store_if.sv
// ============================================================================
// lap_store_if : control, write and read-back signals of the lap store
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface lap_store_if
#(
    parameter int DW = watch_pkg::DW,
    parameter int AW = watch_pkg::AW
);

    logic          clr;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic          rd_rewind;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] rd_age;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          busy;

    modport master (
        output clr, wr_req, wr_data, rd_req, rd_rewind,
        input  rd_data, rd_valid, rd_age, count, full, empty, busy
    );

    modport slave (
        input  clr, wr_req, wr_data, rd_req, rd_rewind,
        output rd_data, rd_valid, rd_age, count, full, empty, busy
    );

endinterface

`default_nettype wire

// File: rtl/lap_store_ram.sv
// ============================================================================
// lap_ram  : single-port synchronous RAM, registered read, 1-cycle latency
// Revision : 1.0
// ============================================================================
`default_nettype none

module lap_ram
#(
    parameter int DW    = 24,
    parameter int DEPTH = 16,
    parameter int AW    = 4
)
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en,
    input  wire logic          we,
    input  wire logic [AW-1:0] addr,
    input  wire logic [DW-1:0] wdata,
    output logic      [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    // Storage is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    // The output register only moves on a read, so it holds the last fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en && !we) begin
            r_q <= r_mem[addr];
        end
    end

    assign rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/lap_store.sv
// ============================================================================
// lap_store : circular store of the last DEPTH lap times with newest-first
//             read-back cursor over a single-port RAM
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lap_store
#(
    parameter int DW    = watch_pkg::DW,
    parameter int DEPTH = watch_pkg::DEPTH
)
(
    input  wire logic  clk,
    input  wire logic  rst,
    lap_store_if.slave bus
);

    import watch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_age;
    logic [AW-1:0] r_rd_age;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_wr_data;

    logic [AW-1:0] w_rd_addr;
    logic [AW:0]   w_age_inc;
    logic          w_ram_en;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_q;

    // Cursor age counts back from the newest record, which sits at wr_ptr-1.
    assign w_rd_addr = r_wr_ptr - AW'(1) - r_age;
    assign w_age_inc = {1'b0, r_age} + (AW+1)'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.wr_req) begin
                    w_next = WR;
                end else if (bus.rd_req && (r_count != '0)) begin
                    w_next = RD_ADDR;
                end
            end
            WR:      w_next = IDLE;
            RD_ADDR: w_next = RD_DATA;
            RD_DATA: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ram_we   = (r_state == WR) && !bus.clr && !rst;
        w_ram_en   = ((r_state == WR) || (r_state == RD_ADDR)) && !bus.clr && !rst;
        w_ram_addr = (r_state == WR) ? r_wr_ptr : w_rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_age     <= '0;
            r_rd_age  <= '0;
            r_count   <= '0;
            r_wr_data <= '0;
        end else if (bus.clr) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_age    <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.wr_req) begin
                        r_wr_data <= bus.wr_data;
                    end else if (w_next == IDLE && bus.rd_rewind) begin
                        r_age <= '0;
                    end
                end
                WR: begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_age    <= '0;
                    if (r_count != C_FULL) begin
                        r_count <= r_count + (AW+1)'(1);
                    end
                end
                RD_ADDR: begin
                    r_rd_age <= r_age;
                    r_age    <= (w_age_inc == r_count) ? '0 : w_age_inc[AW-1:0];
                end
                default: ;
            endcase
        end
    end

    lap_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wr_data),
        .rdata (w_ram_q)
    );

    // Valid is masked in the cycle a clear or reset lands so an aborted fetch never shows.
    assign bus.rd_data  = w_ram_q;
    assign bus.rd_valid = (r_state == RD_DATA) && !bus.clr && !rst;
    assign bus.rd_age   = r_rd_age;
    assign bus.count    = r_count;
    assign bus.full     = (r_count == C_FULL);
    assign bus.empty    = (r_count == '0);
    assign bus.busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lap_store.sv
// ============================================================================
// tb_lap_store : directed self-checking bench for lap_store
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_lap_store;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lap_store_if bus ();

    lap_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] data);
        @(negedge clk);
        bus.wr_req  = 1'b1;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_req  = 1'b0;
    endtask

    // Issues one rd_req; reports rd_valid one and two cycles later plus the data then.
    task automatic do_read(output logic v1, output logic v2,
                           output logic [23:0] data, output logic [3:0] age);
        @(negedge clk);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        v1 = bus.rd_valid;
        @(negedge clk);
        v2   = bus.rd_valid;
        data = bus.rd_data;
        age  = bus.rd_age;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 24'h0 ||
            bus.rd_age !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b busy=%b valid=%b data=%h age=%0d, want 0 1 0 0 0 000000 0",
                     bus.count, bus.empty, bus.full, bus.busy, bus.rd_valid, bus.rd_data, bus.rd_age);
        end
    endtask

    task automatic test_order();
        logic [23:0] exp_d [3];
        logic v1, v2;
        logic [23:0] d;
        logic [3:0]  a;
        exp_d = '{24'h013099, 24'h002500, 24'h001234};
        do_reset();
        do_write(24'h001234);
        do_write(24'h002500);
        do_write(24'h013099);
        @(negedge clk);
        checks++;
        if (bus.count !== 5'd3) begin
            errors++;
            $display("FAIL order_count: got %0d want 3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(v1, v2, d, a);
            checks++;
            if (v1 !== 1'b0 || v2 !== 1'b1 || d !== exp_d[i] || a !== 4'(i)) begin
                errors++;
                $display("FAIL order_read%0d: v1=%b v2=%b data=%h age=%0d, want 0 1 %h %0d",
                         i, v1, v2, d, a, exp_d[i], i);
            end
        end
    endtask

    task automatic test_wrap();
        logic v1, v2;
        logic [23:0] d;
        logic [3:0]  a;
        do_reset();
        for (int i = 1; i <= 17; i++) do_write(24'(i));
        @(negedge clk);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full: full=%b count=%0d empty=%b want 1 16 0", bus.full, bus.count, bus.empty);
        end
        for (int i = 0; i < 17; i++) begin
            do_read(v1, v2, d, a);
            if (i == 0 || i == 15 || i == 16) begin
                checks++;
                if (v2 !== 1'b1 || d !== ((i == 15) ? 24'h000002 : 24'h000011)) begin
                    errors++;
                    $display("FAIL wrap_read%0d: valid=%b data=%h want 1 %h", i + 1, v2, d,
                             (i == 15) ? 24'h000002 : 24'h000011);
                end
            end
        end
    endtask

    task automatic test_empty_and_conflict();
        int pulses;
        int busy_seen;
        do_reset();
        pulses = 0;
        busy_seen = 0;
        @(negedge clk);
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b0;
            if (bus.rd_valid) pulses++;
            if (bus.busy) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL empty_read: valid_pulses=%0d busy_cycles=%0d want 0 0", pulses, busy_seen);
        end
        do_write(24'h000111);
        do_write(24'h000222);
        @(negedge clk);
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        bus.wr_data = 24'h000333;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b0;
            bus.rd_req = 1'b0;
            if (bus.rd_valid) pulses++;
        end
        checks++;
        if (bus.count !== 5'd3 || pulses != 0) begin
            errors++;
            $display("FAIL wr_rd_conflict: count=%0d valid_pulses=%0d want 3 0", bus.count, pulses);
        end
    endtask

    task automatic test_rewind_busy();
        logic v1, v2;
        logic [23:0] d;
        logic [3:0]  a;
        int pulses;
        logic [23:0] last_d;
        do_read(v1, v2, d, a);
        checks++;
        if (v2 !== 1'b1 || d !== 24'h000333 || a !== 4'd0) begin
            errors++;
            $display("FAIL rewind_first: valid=%b data=%h age=%0d want 1 000333 0", v2, d, a);
        end
        do_read(v1, v2, d, a);
        checks++;
        if (v2 !== 1'b1 || d !== 24'h000222 || a !== 4'd1) begin
            errors++;
            $display("FAIL rewind_second: valid=%b data=%h age=%0d want 1 000222 1", v2, d, a);
        end
        @(negedge clk);
        bus.rd_rewind = 1'b1;
        @(negedge clk);
        bus.rd_rewind = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rewind_nofetch: valid=%b busy=%b want 0 0", bus.rd_valid, bus.busy);
        end
        do_read(v1, v2, d, a);
        checks++;
        if (v2 !== 1'b1 || d !== 24'h000333 || a !== 4'd0) begin
            errors++;
            $display("FAIL rewind_after: valid=%b data=%h age=%0d want 1 000333 0", v2, d, a);
        end
        // Second rd_req lands while the first fetch is in RD_ADDR.
        @(negedge clk);
        bus.rd_req = 1'b1;
        pulses = 0;
        last_d = 24'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rd_req = (i == 0);
            if (bus.rd_valid) begin
                pulses++;
                last_d = bus.rd_data;
            end
        end
        checks++;
        if (pulses != 1 || last_d !== 24'h000222) begin
            errors++;
            $display("FAIL busy_drop: valid_pulses=%0d data=%h want 1 000222", pulses, last_d);
        end
    endtask

    task automatic test_clr();
        int pulses;
        @(negedge clk);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.clr    = 1'b1;
        pulses = bus.rd_valid ? 1 : 0;
        @(negedge clk);
        bus.clr = 1'b0;
        if (bus.rd_valid) pulses++;
        checks++;
        if (pulses != 0 || bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort: valid_pulses=%0d count=%0d empty=%b busy=%b want 0 0 1 0",
                     pulses, bus.count, bus.empty, bus.busy);
        end
        @(negedge clk);
        bus.rd_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_req = 1'b0;
            if (bus.rd_valid || bus.busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL clr_then_read: active_cycles=%0d want 0", pulses);
        end
    endtask

    task automatic test_rst_mid_write();
        logic v1, v2;
        logic [23:0] d;
        logic [3:0]  a;
        @(negedge clk);
        bus.wr_req  = 1'b1;
        bus.wr_data = 24'h00ABCD;
        @(negedge clk);
        bus.wr_req = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.busy !== 1'b0 || bus.rd_data !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_write: count=%0d empty=%b busy=%b data=%h want 0 1 0 000000",
                     bus.count, bus.empty, bus.busy, bus.rd_data);
        end
        do_write(24'h005959);
        @(negedge clk);
        checks++;
        if (dut.u_ram.r_mem[0] !== 24'h005959 || bus.count !== 5'd1) begin
            errors++;
            $display("FAIL rst_write_addr0: mem0=%h count=%0d want 005959 1", dut.u_ram.r_mem[0], bus.count);
        end
        do_read(v1, v2, d, a);
        checks++;
        if (v2 !== 1'b1 || d !== 24'h005959 || a !== 4'd0) begin
            errors++;
            $display("FAIL rst_readback: valid=%b data=%h age=%0d want 1 005959 0", v2, d, a);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.clr       = 1'b0;
        bus.wr_req    = 1'b0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_rewind = 1'b0;
        test_reset();
        test_order();
        test_wrap();
        test_empty_and_conflict();
        test_rewind_busy();
        test_clr();
        test_rst_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
